axis_buf_frame_reader: RTL and testbench

//  Read-side engine for the packet buffer RAM: takes a frame descriptor (start word address, byte length),

---
 rtl/eth_axis_pkg.sv | 21 ++
 rtl/axis_prefetch_fifo.sv | 52 +++++
 rtl/axis_buf_frame_reader.sv | 156 +++++++++++++++
 tb/tb_axis_buf_frame_reader.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_axis_pkg.sv
// Shared types and helpers for the packet-buffer AXI-Stream read path.
package eth_axis_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int LEN_W_DEF  = 11;
  localparam int KEEP_MAX   = 64;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [LEN_W_DEF-1:0]  len;
  } buf_desc_t;

  typedef enum logic {IDLE, STREAM} state_t;

  // Byte enables for a final beat holding rem bytes; rem==0 means a full word.
  function automatic logic [KEEP_MAX-1:0] keep_mask(input logic [5:0] rem);
    if (rem == '0) keep_mask = '1;
    else           keep_mask = (KEEP_MAX'(1) << rem) - KEEP_MAX'(1);
  endfunction

endpackage

// File: rtl/axis_prefetch_fifo.sv
// Small synchronous FIFO that absorbs RAM read data while the stream is stalled.
module axis_prefetch_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (wr_en_i) r_mem[r_wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (wr_en_i) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (rd_en_i) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({wr_en_i, rd_en_i})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data_o = r_mem[r_rd_ptr];
  assign empty_o   = (r_count == '0);
  assign count_o   = r_count;

endmodule

// File: rtl/axis_buf_frame_reader.sv
// Reads a descriptor-addressed frame out of the packet buffer RAM and emits it as AXI-Stream.
//   state  | meaning
//   IDLE   | waiting for a descriptor; desc_ready_o high
//   STREAM | issuing RAM reads and presenting beats until the last one is accepted
module axis_buf_frame_reader
  import eth_axis_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                desc_valid_i,
  output logic                desc_ready_o,
  input  logic [ADDR_W-1:0]   desc_addr_i,
  input  logic [LEN_W-1:0]    desc_len_i,
  output logic                ram_en_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  input  logic [DATA_W-1:0]   ram_data_i,
  output logic [DATA_W-1:0]   m_axis_tdata_o,
  output logic [DATA_W/8-1:0] m_axis_tkeep_o,
  output logic                m_axis_tlast_o,
  output logic                m_axis_tvalid_o,
  input  logic                m_axis_tready_i,
  output logic                done_o,
  output logic                err_o
);

  localparam int KEEP_W  = DATA_W / 8;
  localparam int KEEP_LG = (KEEP_W > 1) ? $clog2(KEEP_W) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

  state_t              r_state, w_state_nxt;
  buf_desc_t           w_desc;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_issue_left;
  logic [KEEP_LG-1:0]  r_rem;
  logic                r_in_flight, r_in_last;
  logic                r_tvalid, r_tlast;
  logic [DATA_W-1:0]   r_tdata;
  logic [KEEP_W-1:0]   r_tkeep;
  logic                r_done, r_err;

  logic                w_accept, w_issue, w_last_acc, w_take;
  logic                w_fifo_push, w_fifo_pop, w_fifo_empty, w_src_valid;
  logic [CNT_W-1:0]    w_fifo_count;
  logic [CNT_W:0]      w_occupancy;
  logic [DATA_W:0]     w_fifo_rd, w_src;
  logic [LEN_W:0]      w_len_round;
  logic [KEEP_W-1:0]   w_keep_last;

  assign w_desc       = '{addr: desc_addr_i, len: desc_len_i};
  assign desc_ready_o = (r_state == IDLE);
  assign w_accept     = desc_valid_i && desc_ready_o;
  assign w_len_round  = {1'b0, w_desc.len} + (LEN_W+1)'(KEEP_W - 1);
  assign w_occupancy  = (CNT_W+1)'(w_fifo_count) + (CNT_W+1)'(r_in_flight);
  assign w_last_acc   = r_tvalid && m_axis_tready_i && r_tlast;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && (w_desc.len != '0)) w_state_nxt = STREAM;
      end
      STREAM: begin
        w_issue = (r_issue_left != '0) && (w_occupancy < (CNT_W+1)'(FIFO_DEPTH));
        if (w_last_acc) w_state_nxt = IDLE;
      end
    endcase
  end

  // Issue side: word down-counter and wrapping read address.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr       <= '0;
      r_issue_left <= '0;
      r_rem        <= '0;
      r_in_flight  <= 1'b0;
      r_in_last    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_err       <= w_accept && (w_desc.len == '0);
      r_in_flight <= w_issue;
      r_in_last   <= w_issue && (r_issue_left == LEN_W'(1));
      if (w_accept && (w_desc.len != '0)) begin
        r_addr       <= w_desc.addr;
        r_issue_left <= LEN_W'(w_len_round >> KEEP_LG);
        r_rem        <= w_desc.len[KEEP_LG-1:0];
      end else if (w_issue) begin
        r_addr       <= r_addr + ADDR_W'(1);
        r_issue_left <= r_issue_left - LEN_W'(1);
      end
    end
  end

  // Read data bypasses the FIFO when it is empty so the first beat appears two cycles after the read.
  assign w_take      = !r_tvalid || m_axis_tready_i;
  assign w_fifo_pop  = w_take && !w_fifo_empty;
  assign w_fifo_push = r_in_flight && !(w_take && w_fifo_empty);
  assign w_src       = w_fifo_empty ? {r_in_last, ram_data_i} : w_fifo_rd;
  assign w_src_valid = !w_fifo_empty || r_in_flight;
  assign w_keep_last = KEEP_W'(keep_mask(6'(r_rem)));

  axis_prefetch_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (w_fifo_push),
    .wr_data_i ({r_in_last, ram_data_i}),
    .rd_en_i   (w_fifo_pop),
    .rd_data_o (w_fifo_rd),
    .empty_o   (w_fifo_empty),
    .count_o   (w_fifo_count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_last_acc;
      if (w_take) begin
        r_tvalid <= w_src_valid;
        if (w_src_valid) begin
          r_tlast <= w_src[DATA_W];
          r_tdata <= w_src[DATA_W-1:0];
          r_tkeep <= w_src[DATA_W] ? w_keep_last : '1;
        end
      end
    end
  end

  assign ram_en_o        = w_issue;
  assign ram_addr_o      = r_addr;
  assign m_axis_tdata_o  = r_tdata;
  assign m_axis_tkeep_o  = r_tkeep;
  assign m_axis_tlast_o  = r_tlast;
  assign m_axis_tvalid_o = r_tvalid;
  assign done_o          = r_done;
  assign err_o           = r_err;

endmodule

// File: tb/tb_axis_buf_frame_reader.sv
// Scoreboard bench for axis_buf_frame_reader: expected reads and beats are queued per descriptor.
module tb_axis_buf_frame_reader;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  logic [8:0]  desc_addr = '0;
  logic [10:0] desc_len = '0;
  logic        ram_en;
  logic [8:0]  ram_addr;
  logic [31:0] ram_data = '0;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tlast, m_tvalid;
  logic        m_tready = 1'b1;
  logic        done, err;

  logic [31:0] mem [0:511];
  beat_t       beat_q [$];
  logic [8:0]  addr_q [$];
  int          tv_lat_q [$];
  int          en_lat_q [$];

  int n_cmp = 0, n_fail = 0, cyc = 0;
  int n_beats = 0, n_done = 0, n_errp = 0, n_ram_en = 0, n_tv = 0, n_bubble = 0;
  int accept_cyc = 0;
  bit wait_en = 0, wait_tv = 0, in_frame = 0, prev_stall = 0;
  logic [37:0] held = '0;
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  axis_buf_frame_reader #(
    .ADDR_W(9), .DATA_W(32), .LEN_W(11), .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .desc_valid_i(desc_valid), .desc_ready_o(desc_ready),
    .desc_addr_i(desc_addr), .desc_len_i(desc_len),
    .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_data_i(ram_data),
    .m_axis_tdata_o(m_tdata), .m_axis_tkeep_o(m_tkeep), .m_axis_tlast_o(m_tlast),
    .m_axis_tvalid_o(m_tvalid), .m_axis_tready_i(m_tready),
    .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ram_en) ram_data <= mem[ram_addr];

  // Monitor: pops expected reads/beats, checks hold-under-stall, gathers counts and latencies.
  always @(negedge clk) begin
    beat_t     eb;
    logic [8:0] ea;
    if (rst) begin
      prev_stall = 0; wait_en = 0; wait_tv = 0; in_frame = 0;
    end else begin
      if (prev_stall) begin
        n_cmp++;
        if ({m_tvalid, m_tlast, m_tkeep, m_tdata} !== held) begin
          n_fail++;
          $display("FAIL stall_hold got %h want %h", {m_tvalid, m_tlast, m_tkeep, m_tdata}, held);
        end
      end
      if (ram_en) begin
        n_ram_en++;
        if (wait_en) begin en_lat_q.push_back(cyc - accept_cyc); wait_en = 0; end
        n_cmp++;
        if (addr_q.size() == 0) begin
          n_fail++;
          $display("FAIL ram_extra_read got addr %h want none", ram_addr);
        end else begin
          ea = addr_q.pop_front();
          if (ram_addr !== ea) begin
            n_fail++;
            $display("FAIL ram_addr got %h want %h", ram_addr, ea);
          end
        end
      end
      if (m_tvalid) begin
        n_tv++;
        if (wait_tv) begin tv_lat_q.push_back(cyc - accept_cyc); wait_tv = 0; end
      end
      if (m_tvalid && m_tready) begin
        n_beats++;
        n_cmp++;
        if (beat_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat_extra got data %h keep %h last %b want none", m_tdata, m_tkeep, m_tlast);
        end else begin
          eb = beat_q.pop_front();
          if ({m_tdata, m_tkeep, m_tlast} !== eb) begin
            n_fail++;
            $display("FAIL beat got data %h keep %h last %b want data %h keep %h last %b",
                     m_tdata, m_tkeep, m_tlast, eb.data, eb.keep, eb.last);
          end
        end
        in_frame = !m_tlast;
      end else if (in_frame && !m_tvalid) begin
        n_bubble++;
      end
      if (done) n_done++;
      if (err) n_errp++;
      prev_stall = m_tvalid && !m_tready;
      held = {m_tvalid, m_tlast, m_tkeep, m_tdata};
      if (desc_valid && desc_ready && desc_len != 0) begin
        accept_cyc = cyc + 1; wait_en = 1; wait_tv = 1;
      end
    end
  end

  task automatic push_frame(input logic [8:0] addr, input int len);
    int         words;
    logic [8:0] a;
    beat_t      b;
    words = (len + 3) / 4;
    for (int w = 0; w < words; w++) begin
      a = addr + 9'(w);
      addr_q.push_back(a);
      b.data = mem[a];
      b.last = (w == words - 1);
      b.keep = 4'hF;
      if (b.last && (len % 4) != 0) b.keep = 4'((1 << (len % 4)) - 1);
      beat_q.push_back(b);
    end
  endtask

  task automatic send_desc(input logic [8:0] addr, input int len, output bit to);
    push_frame(addr, len);
    to = 1;
    @(posedge clk); #1;
    desc_valid = 1; desc_addr = addr; desc_len = 11'(len);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (desc_ready) begin to = 0; break; end
    end
    @(posedge clk); #1;
    desc_valid = 0;
  endtask

  task automatic run_until(input int target, input bit rnd, output bit to);
    int k;
    k = 0; to = 1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (rnd) begin
        m_tready = (k < 16) ? pat[k % 4] : 1'($urandom_range(0, 1));
        k++;
      end else m_tready = 1;
      if (n_done >= target && beat_q.size() == 0) begin to = 0; break; end
    end
    m_tready = 1;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({desc_ready, ram_en, ram_addr} !== {1'b1, 1'b0, 9'h000}) begin
      n_fail++; $display("FAIL reset_ctrl got %b want %b", {desc_ready, ram_en, ram_addr}, 11'b10_000000000);
    end
    n_cmp++;
    if ({m_tvalid, m_tlast, m_tkeep, m_tdata} !== 38'h0) begin
      n_fail++; $display("FAIL reset_stream got %h want 0", {m_tvalid, m_tlast, m_tkeep, m_tdata});
    end
    n_cmp++;
    if ({done, err} !== 2'b00) begin
      n_fail++; $display("FAIL reset_pulses got %b want 00", {done, err});
    end
    @(posedge clk); #1; rst = 0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({desc_ready, ram_en, m_tvalid, done, err} !== 5'b10000) begin
      n_fail++; $display("FAIL idle_after_reset got %b want 10000", {desc_ready, ram_en, m_tvalid, done, err});
    end
  endtask

  task automatic test_basic;
    bit to;
    int d0, b0;
    d0 = n_done; b0 = n_beats;
    m_tready = 1;
    send_desc(9'h010, 8, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL basic_accept got timeout want accept"); end
    run_until(d0 + 1, 0, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL basic_timeout got timeout want done"); end
    repeat (3) @(negedge clk);
    n_cmp++; if (n_done - d0 != 1) begin n_fail++; $display("FAIL basic_done got %0d want 1", n_done - d0); end
    n_cmp++; if (n_beats - b0 != 2) begin n_fail++; $display("FAIL basic_beats got %0d want 2", n_beats - b0); end
    n_cmp++;
    if (en_lat_q.size() != 1 || en_lat_q[0] != 0) begin
      n_fail++; $display("FAIL basic_ram_en_latency got %p want '{0}", en_lat_q);
    end
    n_cmp++;
    if (tv_lat_q.size() != 1 || tv_lat_q[0] != 2) begin
      n_fail++; $display("FAIL basic_tvalid_latency got %p want '{2}", tv_lat_q);
    end
    n_cmp++; if (n_bubble != 0) begin n_fail++; $display("FAIL basic_bubbles got %0d want 0", n_bubble); end
    en_lat_q.delete(); tv_lat_q.delete();
  endtask

  task automatic test_wrap;
    bit to;
    int d0, b0;
    d0 = n_done; b0 = n_beats;
    send_desc(9'h1FF, 5, to);
    run_until(d0 + 1, 0, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL wrap_timeout got timeout want done"); end
    repeat (2) @(negedge clk);
    n_cmp++; if (n_beats - b0 != 2) begin n_fail++; $display("FAIL wrap_beats got %0d want 2", n_beats - b0); end
    n_cmp++; if (addr_q.size() != 0) begin n_fail++; $display("FAIL wrap_reads_left got %0d want 0", addr_q.size()); end
    en_lat_q.delete(); tv_lat_q.delete();
  endtask

  task automatic test_backpressure;
    bit to;
    int d0, b0, r0;
    d0 = n_done; b0 = n_beats; r0 = n_ram_en;
    send_desc(9'h040, 64, to);
    run_until(d0 + 1, 1, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL bp_timeout got timeout want done"); end
    repeat (3) @(negedge clk);
    n_cmp++; if (n_beats - b0 != 16) begin n_fail++; $display("FAIL bp_beats got %0d want 16", n_beats - b0); end
    n_cmp++; if (n_ram_en - r0 != 16) begin n_fail++; $display("FAIL bp_reads got %0d want 16", n_ram_en - r0); end
    n_cmp++; if (n_done - d0 != 1) begin n_fail++; $display("FAIL bp_done got %0d want 1", n_done - d0); end
    en_lat_q.delete(); tv_lat_q.delete();
  endtask

  task automatic test_zero_len;
    bit to;
    int e0, r0, t0, low;
    e0 = n_errp; r0 = n_ram_en; t0 = n_tv; low = 0;
    send_desc(9'h020, 0, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL zero_accept got timeout want accept"); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!desc_ready) low++;
    end
    n_cmp++; if (n_errp - e0 != 1) begin n_fail++; $display("FAIL zero_err got %0d pulses want 1", n_errp - e0); end
    n_cmp++; if (n_ram_en - r0 != 0) begin n_fail++; $display("FAIL zero_reads got %0d want 0", n_ram_en - r0); end
    n_cmp++; if (n_tv - t0 != 0) begin n_fail++; $display("FAIL zero_tvalid got %0d cycles want 0", n_tv - t0); end
    n_cmp++; if (low != 0) begin n_fail++; $display("FAIL zero_desc_ready got %0d low cycles want 0", low); end
  endtask

  task automatic test_reset_mid;
    bit to, hit;
    int d0, b0;
    b0 = n_beats; hit = 0;
    m_tready = 1;
    send_desc(9'h080, 40, to);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (n_beats - b0 >= 3) begin hit = 1; break; end
    end
    n_cmp++; if (!hit) begin n_fail++; $display("FAIL rstmid_beat3 got timeout want 3 beats"); end
    #1; rst = 1;
    beat_q.delete(); addr_q.delete(); en_lat_q.delete(); tv_lat_q.delete();
    d0 = n_done;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    n_cmp++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_tvalid got %b want 0", m_tvalid); end
    repeat (4) @(negedge clk);
    n_cmp++; if (n_done != d0) begin n_fail++; $display("FAIL rstmid_done got %0d pulses want 0", n_done - d0); end
    b0 = n_beats;
    send_desc(9'h100, 4, to);
    run_until(d0 + 1, 0, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL rstmid_new_timeout got timeout want done"); end
    repeat (2) @(negedge clk);
    n_cmp++; if (n_beats - b0 != 1) begin n_fail++; $display("FAIL rstmid_new_beats got %0d want 1", n_beats - b0); end
    en_lat_q.delete(); tv_lat_q.delete();
  endtask

  task automatic test_back_to_back;
    bit to1, to2, to;
    int d0, b0, bub0;
    d0 = n_done; b0 = n_beats; bub0 = n_bubble;
    m_tready = 1;
    send_desc(9'h030, 12, to1);
    send_desc(9'h038, 12, to2);
    run_until(d0 + 2, 0, to);
    n_cmp++; if (to1 || to2 || to) begin n_fail++; $display("FAIL b2b_timeout got %b%b%b want 000", to1, to2, to); end
    repeat (3) @(negedge clk);
    n_cmp++; if (n_done - d0 != 2) begin n_fail++; $display("FAIL b2b_done got %0d want 2", n_done - d0); end
    n_cmp++; if (n_beats - b0 != 6) begin n_fail++; $display("FAIL b2b_beats got %0d want 6", n_beats - b0); end
    n_cmp++;
    if (tv_lat_q.size() != 2 || tv_lat_q[0] != 2 || tv_lat_q[1] != 2) begin
      n_fail++; $display("FAIL b2b_tvalid_latency got %p want '{2,2}", tv_lat_q);
    end
    n_cmp++; if (n_bubble != bub0) begin n_fail++; $display("FAIL b2b_bubbles got %0d want 0", n_bubble - bub0); end
    en_lat_q.delete(); tv_lat_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = {8'hD0 ^ 8'(i), 8'(i * 3), 8'(~i), 8'(i + 7)};
    mem[9'h010] = 32'hA0A1A2A3;
    mem[9'h011] = 32'hB0B1B2B3;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
    test_back_to_back();
    n_cmp++;
    if (beat_q.size() != 0 || addr_q.size() != 0) begin
      n_fail++; $display("FAIL leftover got %0d beats %0d reads want 0 0", beat_q.size(), addr_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
